// File: rtl/zigbee_tx_pkg.sv
// Shared types and constants for the ZigBee Tx frame sequencer.
package zigbee_tx_pkg;

    localparam int BIT_CNT_W          = 11;
    localparam int MAX_LEN_DEFAULT    = 127;
    localparam int HDR_BYTES_DEFAULT  = 6;
    localparam int IFS_CYCLES_DEFAULT = 9600;
    localparam int TO_CYCLES_DEFAULT  = 1024;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_TX        = 2'd2,
        ST_GUARD     = 2'd3
    } tx_ctrl_state_e;

    typedef enum logic [1:0] {
        ERR_LEN      = 2'd0,
        ERR_UNDERRUN = 2'd1,
        ERR_ABORT    = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } tx_err_e;

    // Total bits on air for a frame: header plus PSDU, eight bits per byte.
    function automatic logic [BIT_CNT_W-1:0] frame_bits(input int hdr_bytes,
                                                        input logic [6:0] len);
        int total;
        total = (hdr_bytes + int'(len)) * 8;
        return total[BIT_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/zigbee_tx_ctrl_iq_fall_detect.sv
// Falling-edge detector for the FIFO bit strobe; shared with the Rx side.
module iq_fall_detect (
    input  logic clk,
    input  logic reset,
    input  logic iq_rate,
    output logic fall
);

    logic iq_rate_d;
    logic iq_rate_q;

    // Next value of the strobe delay register.
    always_comb begin
        iq_rate_d = iq_rate;
    end

    // One-cycle delay of the strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            iq_rate_q <= 1'b0;
        end else begin
            iq_rate_q <= iq_rate_d;
        end
    end

    assign fall = iq_rate_q & ~iq_rate;

endmodule

// File: rtl/zigbee_tx_ctrl.sv
// Tx frame sequencer: start/length check, FIFO read enable for the whole
// frame, underrun/abort detection and inter-frame guard.
// Optional feature macro: TX_TIMEOUT_EN (WAIT_DATA timeout, err_code 3).
module zigbee_tx_ctrl
    import zigbee_tx_pkg::*;
#(
    parameter int MAX_LEN    = MAX_LEN_DEFAULT,
    parameter int HDR_BYTES  = HDR_BYTES_DEFAULT,
    parameter int IFS_CYCLES = IFS_CYCLES_DEFAULT,
    parameter int TO_CYCLES  = TO_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [6:0] frame_len,
    input  logic       tx_abort,
    input  logic       mem_state,
    input  logic       IQ_rate,
    output logic       en_IQ,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code
);

    // Guard and timeout share one down-counter, sized for the larger load.
    localparam int CNT_MAX = (IFS_CYCLES > TO_CYCLES) ? IFS_CYCLES : TO_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    tx_ctrl_state_e         state_d, state_q;
    logic [BIT_CNT_W-1:0]   total_bits_d, total_bits_q;
    logic [BIT_CNT_W-1:0]   bits_done_d, bits_done_q;
    logic [BIT_CNT_W-1:0]   bits_next;
    logic [CNT_W-1:0]       cnt_d, cnt_q;
    logic                   en_iq_d, en_iq_q;
    logic                   busy_d, busy_q;
    logic                   done_d, done_q;
    logic                   err_d, err_q;
    tx_err_e                err_code_d, err_code_q;
    logic                   fall;
    logic                   last_fall;
    logic                   len_ok;

    iq_fall_detect u_fall (
        .clk     (clk),
        .reset   (reset),
        .iq_rate (IQ_rate),
        .fall    (fall)
    );

    assign bits_next = bits_done_q + 1'b1;
    assign last_fall = fall && (bits_next == total_bits_q);
    assign len_ok    = (frame_len != 7'd0) && (int'(frame_len) <= MAX_LEN);

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        total_bits_d = total_bits_q;
        bits_done_d  = bits_done_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        err_code_d   = err_code_q;

        unique case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    if (len_ok) begin
                        total_bits_d = frame_bits(HDR_BYTES, frame_len);
                        bits_done_d  = '0;
                        state_d      = ST_WAIT_DATA;
`ifdef TX_TIMEOUT_EN
                        cnt_d        = CNT_W'(TO_CYCLES - 1);
`endif
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_LEN;
                    end
                end
            end
            ST_WAIT_DATA: begin
                if (tx_abort) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    err_code_d = ERR_ABORT;
                end else if (mem_state) begin
                    state_d = ST_TX;
                end
`ifdef TX_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`endif
            end
            ST_TX: begin
                // Completing fall outranks an empty FIFO: the last byte's
                // pointer advance lands on the same cycle as its last bit.
                if (tx_abort) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    err_code_d = ERR_ABORT;
                end else if (last_fall) begin
                    bits_done_d = bits_next;
                    cnt_d       = CNT_W'(IFS_CYCLES - 1);
                    state_d     = ST_GUARD;
                end else if (!mem_state) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    err_code_d = ERR_UNDERRUN;
                end else if (fall) begin
                    bits_done_d = bits_next;
                end
            end
            ST_GUARD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        en_iq_d = (state_d == ST_TX);
        busy_d  = (state_d != ST_IDLE);
    end

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            total_bits_q <= '0;
            bits_done_q  <= '0;
            cnt_q        <= '0;
            en_iq_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_LEN;
        end else begin
            state_q      <= state_d;
            total_bits_q <= total_bits_d;
            bits_done_q  <= bits_done_d;
            cnt_q        <= cnt_d;
            en_iq_q      <= en_iq_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign en_IQ    = en_iq_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;
    assign tx_err   = err_q;
    assign err_code = err_code_q;

endmodule
